// File: rtl/tick_pkg.sv
// tick_pkg: shared definitions for the tick scheduler slice.
//   - sched_state_t : engine state encoding (IDLE / RUN / DONE)
//   - TICK_DIV_SIM / TICK_DIV_SILICON : default clocks-per-tick for the
//     simulation build (1 us at 50 MHz) and the silicon build (1 s at 50 MHz)
package tick_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    localparam int TICK_DIV_SIM     = 50;
    localparam int TICK_DIV_SILICON = 50_000_000;

endpackage

// File: rtl/tick_scheduler_if.sv
// tick_scheduler_if: requester-side bundle of the shared delay engine.
//   req    : per-requester request level
//   dly    : packed per-requester delays, slice i = dly[i*DLY_W +: DLY_W]
//   busy   : one-hot owner of the engine
//   done   : one-cycle completion pulse to the owner
//   active : engine not idle
//   remain : ticks left for the current owner (0 when idle)
// Modports: master = requester side, slave = scheduler side.
interface tick_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int DLY_W = 8
) ();

    logic [N_REQ-1:0]       req;
    logic [N_REQ*DLY_W-1:0] dly;
    logic [N_REQ-1:0]       busy;
    logic [N_REQ-1:0]       done;
    logic                   active;
    logic [DLY_W-1:0]       remain;

    modport master (
        output req,
        output dly,
        input  busy,
        input  done,
        input  active,
        input  remain
    );

    modport slave (
        input  req,
        input  dly,
        output busy,
        output done,
        output active,
        output remain
    );

endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk down to a single-cycle tick strobe.
// Ports:
//   clk     in  system clock
//   reset_n in  asynchronous active-low reset
//   clear   in  restart the count at 0 on the next edge
//   enable  in  count this cycle
//   tick    out high while enabled and the count is at TICK_DIV-1
module tick_prescaler #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] CNT_LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt_q;

    assign tick = enable && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + TICK_W'(1);
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// tick_scheduler: time-shares one prescaler + down-counter between N_REQ
// requesters. A round-robin arbiter hands the engine to one requester,
// which receives a one-cycle done pulse after its requested number of ticks.
// Ports:
//   clk     in  system clock, rising edge
//   reset_n in  asynchronous active-low reset
//   bus     slave side of tick_scheduler_if (req/dly in; busy/done/active/remain out)
module tick_scheduler
    import tick_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DLY_W    = 8,
    parameter int TICK_DIV = TICK_DIV_SIM
) (
    input logic             clk,
    input logic             reset_n,
    tick_scheduler_if.slave bus
);

    localparam int OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    sched_state_t     state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [OWN_W-1:0] ptr_q, ptr_d;
    logic [DLY_W-1:0] remain_q, remain_d;
    logic             grant;
    logic             tick;
    logic             run_en;
    logic [OWN_W:0]   pick;
    logic [DLY_W-1:0] pick_dly;

    // Returns {found, index} of the first requester at or after ptr.
    // Scanning offsets from the far end downwards lets the nearest hit win.
    function automatic logic [OWN_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [OWN_W-1:0] ptr);
        logic [OWN_W:0]   res;
        logic [OWN_W-1:0] sel;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sel = OWN_W'((int'(ptr) + i) % N_REQ);
            if (r[sel]) begin
                res = {1'b1, sel};
            end
        end
        return res;
    endfunction

    function automatic logic [OWN_W-1:0] next_idx(input logic [OWN_W-1:0] idx);
        return (idx == OWN_W'(N_REQ - 1)) ? '0 : idx + OWN_W'(1);
    endfunction

    assign pick     = rr_pick(bus.req, ptr_q);
    assign pick_dly = bus.dly[int'(pick[OWN_W-1:0]) * DLY_W +: DLY_W];
    assign run_en   = (state_q == ST_RUN);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (grant),
        .enable  (run_en),
        .tick    (tick)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        ptr_d    = ptr_q;
        remain_d = remain_q;
        grant    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                remain_d = '0;
                if (pick[OWN_W]) begin
                    grant    = 1'b1;
                    owner_d  = pick[OWN_W-1:0];
                    remain_d = pick_dly;
                    state_d  = (pick_dly != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                // Withdrawal takes precedence over a coincident final tick.
                if (!bus.req[owner_q]) begin
                    state_d  = ST_IDLE;
                    remain_d = '0;
                    ptr_d    = next_idx(owner_q);
                end else if (tick) begin
                    remain_d = remain_q - DLY_W'(1);
                    if (remain_q == DLY_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = next_idx(owner_q);
            end
            default: begin
                state_d  = ST_IDLE;
                remain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            ptr_q    <= '0;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            ptr_q    <= ptr_d;
            remain_q <= remain_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        bus.busy = '0;
        bus.done = '0;
        if (state_q != ST_IDLE) begin
            bus.busy[owner_q] = 1'b1;
        end
        if (state_q == ST_DONE) begin
            bus.done[owner_q] = 1'b1;
        end
    end

    assign bus.active = (state_q != ST_IDLE);
    assign bus.remain = remain_q;

    a_busy_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.busy));
    a_done_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(bus.done));
    a_done_owner: assert property (@(posedge clk) disable iff (!reset_n)
        ((bus.done & ~bus.busy) == '0));

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
- Time-shares one delay engine between N_REQ requesters. The engine is a tick prescaler plus a down-counter, the same kind of resource as the team's one-shot interval timer.
- Each requester asks for a one-shot delay of D ticks. A round-robin arbiter grants the engine to one requester at a time, and the block returns a one-cycle done pulse to the owner.
- Sits between the control FSMs and the shared timebase, replacing per-FSM private timers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DLY_W, 8, width of each requested delay, in ticks.
- TICK_DIV, 50, clocks per tick. 50 gives 1 us at 50 MHz for simulation; the silicon build sets 50_000_000 (1 s).
- TICK_W, $clog2(TICK_DIV), prescaler width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester request level; held high until done or until withdrawn.
- dly  in  N_REQ*DLY_W  packed delays; slice i = dly[i*DLY_W +: DLY_W]; sampled only at grant.
- busy  out  N_REQ  one-hot: current owner of the engine (RUN or DONE state).
- done  out  N_REQ  one-cycle completion pulse to the owner.
- active  out  1  engine not IDLE.
- remain  out  DLY_W  ticks left for the current owner (debug); 0 when IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, active=0, remain=0; prescaler=0; RR pointer=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, any req high:
  - Pick the first requester at or after the RR pointer (wrapping modulo N_REQ).
  - Call this cycle G. At the G edge, latch owner and dly slice, clear the prescaler, set busy[owner].
  - Go to RUN if dly≠0, or directly to DONE if dly=0.
- IDLE, req=0: stay in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and raises tick when count==TICK_DIV-1, then wraps.
  - Each tick decrements remain. The tick that takes remain from 1 to 0 moves the FSM to DONE.
  - The D-th tick falls on cycle G+D*TICK_DIV.
- DONE:
  - Lasts exactly one cycle. done[owner]=1 and busy[owner] stays 1.
  - Next state is IDLE. RR pointer = owner+1 mod N_REQ.
- Latency:
  - done is high in cycle G+D*TICK_DIV+1.
  - For D=0, done is high in cycle G+1.
  - Earliest next grant is the cycle after DONE; the engine has one idle cycle between owners.
- Withdrawal:
  - If req[owner] falls during RUN, go to IDLE on the next edge. No done pulse; busy clears; RR pointer = owner+1.
  - A req falling in the DONE cycle does not suppress done.
- Re-request: if the owner still holds req in the cycle after done, it is treated as a new request and is subject to round-robin order.
- Non-owner requests: wait silently; dly changes before grant are ignored. Changes to the owner's dly slice after grant are ignored.
- Simultaneous events: a new request arriving in the DONE cycle is arbitrated in the following IDLE cycle.
- Reset mid-RUN: immediate abort, no done, all state to reset values.
- Width rules:
  - remain is unsigned DLY_W; it never underflows because DONE occurs at 0.
  - Maximum delay is (2^DLY_W−1)*TICK_DIV clocks.
- Only one bit of busy and of done may ever be set. Assertions: $onehot0(busy), $onehot0(done), done implies busy.

Decomposition:
- Shared package tick_pkg: state encoding (IDLE/RUN/DONE) and default TICK_DIV constants for SIM vs silicon builds.
- One sub-module: tick_prescaler. Inputs: clk, reset_n, clear, enable. Output: tick. Parameter: TICK_DIV.
- The round-robin pick stays inline as a combinational function in tick_scheduler.

Test Plan:
- req[1]=1, dly[1]=3, TICK_DIV=50, grant at cycle G:
  - expect busy=4'b0010 from G+1;
  - expect done=4'b0010 only in G+151;
  - expect active=0 in G+152.
- req[0] and req[2] rise in the same cycle after reset, both dly=1:
  - expect the owner sequence 0 then 2;
  - expect done[0] at G+51;
  - expect req[2] granted at G+52 and done[2] at G+52+51.
- All four reqs held high, dly=0:
  - expect done pulses in order 0,1,2,3,0,1;
  - expect each done to follow its grant by 1 cycle;
  - expect grants spaced every 2 cycles.
- req[3] granted with dly=10, then req[3] dropped at tick 4 while req[1] is pending:
  - expect no done[3], busy[3] cleared;
  - expect req[1] granted next.
- reset_n pulsed low mid-RUN (remain=5):
  - expect all outputs 0 asynchronously and RR pointer=0;
  - after release with req[2] high, expect grant to 2.
- Owner changes dly after grant, from 2 to 9:
  - expect done exactly 2*TICK_DIV+1 cycles after grant.
